// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one FIFO-style SRAM controller port between four requesters
//   (0 host write, 1 host read, 2 config/cmd write, 3 radio read).
//   Round-robin grant, full/empty gating, per-access watchdog.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req[3:0]            per-requester request level
//   req_we[3:0]         per-requester direction (1 = write)
//   req_wdata[4*DW-1:0] per-requester write data, slice i*DW +: DW
//   hint[3:0]           one-cycle completion pulse to the granted requester
//   err[3:0]            one-cycle abort pulse (coincides with hint)
//   rdata[DW-1:0]       read data, valid from hint until the next completion
//   mem_read/mem_write  strobes to the SRAM controller
//   mem_wdata[DW-1:0]   write data to the SRAM controller
//   mem_done            SRAM controller completion
//   mem_rdata[DW-1:0]   SRAM read data, valid with mem_done
//   mem_full/mem_empty  SRAM FIFO status
//   busy                high whenever an access is in flight
//   cur_grant[1:0]      index of the current or last granted requester
module sram_port_arbiter #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        req,
  input  logic [3:0]        req_we,
  input  logic [4*DW-1:0]   req_wdata,
  output logic [3:0]        hint,
  output logic [3:0]        err,
  output logic [DW-1:0]     rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_done,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_full,
  input  logic              mem_empty,
  output logic              busy,
  output logic [1:0]        cur_grant
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};

  // First requester with req set, searching cyclically from last+1;
  // the last granted requester is considered last of all.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cur_grant_q, cur_grant_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    hint_q, hint_d;
  logic [3:0]    err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;

  logic [DW-1:0] wdata_arr_s [4];
  logic [1:0]    rr_winner_s;
  logic [3:0]    grant_onehot_s;
  logic [TW-1:0] timer_inc_s;
  logic          timeout_s;

  for (genvar i = 0; i < 4; i++) begin : g_wdata
    assign wdata_arr_s[i] = req_wdata[i*DW +: DW];
  end

  assign rr_winner_s    = rr_pick(req, cur_grant_q);
  assign grant_onehot_s = 4'b0001 << cur_grant_q;
  // Saturating increment: the watchdog never wraps back to zero.
  assign timer_inc_s    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;
  assign timeout_s      = (timer_q >= TIMEOUT_C);

  // Next-state and next-output logic for the grant/issue/wait/release FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cur_grant_d = cur_grant_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    hint_d      = 4'b0000;
    err_d       = 4'b0000;
    rdata_d     = rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          cur_grant_d = rr_winner_s;
          we_d        = req_we[rr_winner_s];
          wdata_d     = wdata_arr_s[rr_winner_s];
          timer_d     = {TW{1'b0}};
          state_d     = S_ISSUE;
        end else begin
          state_d     = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (!req[cur_grant_q]) begin
          // Requester gave up before the strobe went out: silent return.
          state_d = S_IDLE;
        end else if (timeout_s) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rdata_d     = {DW{1'b1}};
          hint_d      = grant_onehot_s;
          err_d       = grant_onehot_s;
          state_d     = S_RELEASE;
        end else if (we_q ? mem_full : mem_empty) begin
          timer_d = timer_inc_s;
        end else begin
          mem_write_d = we_q;
          mem_read_d  = !we_q;
          mem_wdata_d = we_q ? wdata_q : mem_wdata_q;
          timer_d     = timer_inc_s;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        // mem_done is tested first so it wins over a same-cycle timeout.
        if (mem_done) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          hint_d  = grant_onehot_s;
          state_d = S_RELEASE;
        end else if (timeout_s) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rdata_d     = {DW{1'b1}};
          hint_d      = grant_onehot_s;
          err_d       = grant_onehot_s;
          state_d     = S_RELEASE;
        end else begin
          timer_d = timer_inc_s;
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // busy covers every non-idle state and stretches one cycle past the
    // return to IDLE, so it falls two cycles after the hint.
    busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= {TW{1'b0}};
      cur_grant_q <= 2'd3;
      we_q        <= 1'b0;
      wdata_q     <= {DW{1'b0}};
      hint_q      <= 4'b0000;
      err_q       <= 4'b0000;
      rdata_q     <= {DW{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= {DW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_grant_q <= cur_grant_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      hint_q      <= hint_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign hint      = hint_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign cur_grant = cur_grant_q;

endmodule
